fp_div_norm_round: RTL

Post-processing stage directly downstream of the iterative FP divider. It captures the divider's raw sign, 9-bit biased exponent and 49-bit quotient on `done_div`, then handles IEEE-754 single-precision special operands. It normalizes the quotient (multi-cycle, one bit per cycle), denormalizes on underflow, rounds to nearest-even, and presents a packed 32-bit result with exception flags to the FPU writeback mux.

---
 rtl/fp_div_pkg.sv | 35 +++
 rtl/fp_special_classify.sv | 28 ++
 rtl/fp_div_norm_round.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared types and constants for the FP divider post-processing stage.
// Contents: FSM state enum, IEEE single constants, flag bit positions,
// and a helper that maps the divider's 9-bit biased exponent onto a signed value.
package fp_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DENORM,
    ROUND,
    OUT
  } state_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          EXP_MAX = 255;
  localparam int          BIAS    = 127;
  localparam int          MAN_W   = 48;

  // Smallest biased exponent that still encodes a normal number.
  localparam int MIN_NORM_EXP = BIAS - 126;

  // Bit positions inside the 5-bit flags vector.
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  // 0x000-0x17F are non-negative; 0x180-0x1FF are exp_raw - 512.
  // Duplicating bit 8 only when bits [8:7] are both set does exactly that.
  function automatic logic signed [9:0] decode_exp(input logic [8:0] exp_raw);
    return $signed({exp_raw[8] & exp_raw[7], exp_raw});
  endfunction

endpackage

// File: rtl/fp_special_classify.sv
// fp_special_classify: flags one IEEE single operand as NaN, infinity or zero.
// Latency: combinational.  Backpressure: none.
// Ports: op (32-bit operand) -> is_nan, is_inf, is_zero.
module fp_special_classify (
  input  logic [31:0] op,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero
);

  logic exp_ones;
  logic exp_zero;
  logic frac_zero;
  logic sign_unused;

  assign exp_ones  = &op[30:23];
  assign exp_zero  = ~|op[30:23];
  assign frac_zero = ~|op[22:0];

  // Sign does not affect the class; the result sign comes from the divider.
  assign sign_unused = op[31];

  // Denormal operands are finite nonzero here; the divider already consumed them.
  assign is_nan  = exp_ones & ~frac_zero;
  assign is_inf  = exp_ones & frac_zero;
  assign is_zero = exp_zero & frac_zero;

endmodule

// File: rtl/fp_div_norm_round.sv
// fp_div_norm_round: normalizes, denormalizes and RNE-rounds the FP divider quotient.
// Latency: done_div in cycle n -> valid in n+3+left_shifts+right_shifts; special operands n+1.
// Backpressure: stall freezes every register (including a pending valid pulse).
// Ports: clk, rstn (sync active-low), stall, sel, done_div, a_in/b_in (operands for
//        special-case classification), sign_in/exp_in/man_in (raw divider result) ->
//        result (packed single), valid (1-cycle pulse), busy (not IDLE), flags
//        {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_div_norm_round
  import fp_div_pkg::*;
#(
  parameter int MAX_RSH = 26
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic [1:0]  sel,
  input  logic        done_div,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        sign_in,
  input  logic [8:0]  exp_in,
  input  logic [48:0] man_in,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy,
  output logic [4:0]  flags
);

  localparam logic signed [9:0] E_MIN_NORM = 10'(MIN_NORM_EXP);
  localparam logic signed [9:0] E_OVF      = 10'(EXP_MAX);
  localparam logic [7:0]        LSH_MAX    = 8'(MAN_W - 1);
  localparam logic [7:0]        RSH_MAX    = 8'(MAX_RSH);

  state_t             state;
  logic               sign_q;
  logic signed [9:0]  e_q;
  logic [MAN_W-1:0]   m_q;
  logic               sticky_q;
  logic               tiny_q;
  logic [7:0]         cnt_q;

  // ---------------------------------------------------------------------------
  // Special-operand classification, resolved in the capture cycle
  // ---------------------------------------------------------------------------
  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;

  fp_special_classify u_cls_a (
    .op      (a_in),
    .is_nan  (a_nan),
    .is_inf  (a_inf),
    .is_zero (a_zero)
  );

  fp_special_classify u_cls_b (
    .op      (b_in),
    .is_nan  (b_nan),
    .is_inf  (b_inf),
    .is_zero (b_zero)
  );

  logic        capture;
  logic        special_hit;
  logic [31:0] spec_res;
  logic [4:0]  spec_flags;
  logic        man_unused;

  assign capture = done_div && (sel == 2'b11);

  // Quotient of two values in [1,2) lies in (0.5,2): bit 48 never carries information.
  assign man_unused = man_in[48];

  always_comb begin
    special_hit = 1'b1;
    spec_res    = '0;
    spec_flags  = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res                = QNAN;
      spec_flags[FLG_INVALID] = 1'b1;
    end else if (b_zero) begin
      spec_res                = {sign_in, 8'hFF, 23'd0};
      spec_flags[FLG_DIVZERO] = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_in, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      spec_res = {sign_in, 31'd0};
    end else begin
      special_hit = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-to-nearest-even on m_q[47:24]
  // ---------------------------------------------------------------------------
  logic              guard_bit;
  logic              lsb_bit;
  logic              sticky_all;
  logic              round_up;
  logic              inexact;
  logic              ovf;
  logic [24:0]       rnd_sum;
  logic signed [9:0] e_fin;
  logic [22:0]       frac_fin;
  logic [7:0]        exp_field;
  logic [31:0]       round_res;
  logic [4:0]        round_flags;

  always_comb begin
    lsb_bit    = m_q[24];
    guard_bit  = m_q[23];
    sticky_all = (|m_q[22:0]) | sticky_q;
    round_up   = guard_bit & (sticky_all | lsb_bit);
    inexact    = guard_bit | sticky_all;
    rnd_sum    = {1'b0, m_q[47:24]} + {24'd0, round_up};

    // A carry out of the 24-bit significand renormalizes by one position.
    e_fin    = e_q + $signed({9'd0, rnd_sum[24]});
    frac_fin = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];

    // Denormal results sit at the e==1 scale but encode exponent 0, unless
    // rounding carried into the hidden bit, which promotes them to exponent 1.
    if (tiny_q) begin
      exp_field = {7'd0, rnd_sum[23]};
    end else begin
      exp_field = e_fin[7:0];
    end

    ovf = !tiny_q && (e_fin >= E_OVF);

    round_flags = '0;
    if (ovf) begin
      round_res = {sign_q, 8'hFF, 23'd0};
    end else begin
      round_res = {sign_q, exp_field, frac_fin};
    end
    round_flags[FLG_OVERFLOW]  = ovf;
    round_flags[FLG_UNDERFLOW] = tiny_q & inexact;
    round_flags[FLG_INEXACT]   = inexact | ovf;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      sticky_q <= 1'b0;
      tiny_q   <= 1'b0;
      cnt_q    <= '0;
      result   <= '0;
      flags    <= '0;
      valid    <= 1'b0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (capture) begin
            sign_q   <= sign_in;
            e_q      <= decode_exp(exp_in);
            m_q      <= man_in[MAN_W-1:0];
            sticky_q <= 1'b0;
            tiny_q   <= 1'b0;
            cnt_q    <= '0;
            if (special_hit) begin
              result <= spec_res;
              flags  <= spec_flags;
              valid  <= 1'b1;
              state  <= OUT;
            end else begin
              state <= NORM;
            end
          end
        end

        NORM: begin
          // One left shift per cycle; the count cap bounds a zero quotient.
          if (!m_q[MAN_W-1] && (cnt_q < LSH_MAX)) begin
            m_q   <= m_q << 1;
            e_q   <= e_q - 10'sd1;
            cnt_q <= cnt_q + 8'd1;
          end else if (e_q >= E_MIN_NORM) begin
            state <= ROUND;
          end else begin
            tiny_q <= 1'b1;
            cnt_q  <= '0;
            state  <= DENORM;
          end
        end

        DENORM: begin
          m_q      <= m_q >> 1;
          sticky_q <= sticky_q | m_q[0];
          e_q      <= e_q + 10'sd1;
          cnt_q    <= cnt_q + 8'd1;
          // Past MAX_RSH shifts every significant bit is below the guard bit,
          // so further shifting only changes sticky, which is already set.
          if ((e_q == E_MIN_NORM - 10'sd1) || (cnt_q + 8'd1 == RSH_MAX)) begin
            state <= ROUND;
          end
        end

        ROUND: begin
          result <= round_res;
          flags  <= round_flags;
          valid  <= 1'b1;
          state  <= OUT;
        end

        OUT: begin
          valid <= 1'b0;
          state <= IDLE;
        end

        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
